// File: rtl/big_core_mul_div_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
interface big_core_mul_div_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) ();
  logic             ReqValid;
  logic             ReqReady;
  logic [2:0]       ReqFunct3;
  logic [XLEN-1:0]  ReqRs1;
  logic [XLEN-1:0]  ReqRs2;
  logic [TAG_W-1:0] ReqTag;
  logic             Flush;
  logic             RspValid;
  logic             RspReady;
  logic [XLEN-1:0]  RspData;
  logic [TAG_W-1:0] RspTag;
  logic             Busy;

  // Core side
  modport master (
    output ReqValid, ReqFunct3, ReqRs1, ReqRs2, ReqTag, Flush, RspReady,
    input  ReqReady, RspValid, RspData, RspTag, Busy
  );

  // Execution unit side
  modport slave (
    input  ReqValid, ReqFunct3, ReqRs1, ReqRs2, ReqTag, Flush, RspReady,
    output ReqReady, RspValid, RspData, RspTag, Busy
  );
endinterface

// File: rtl/big_core_mul_div.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with tagged results,
// valid/ready handshake on both sides and synchronous flush.
module big_core_mul_div #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input logic              Clk,
  input logic              Rst,
  big_core_mul_div_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL, DIV_PREP, DIV_ITER, DIV_FIX, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       funct3Q;
  logic [TAG_W-1:0] tagQ;
  logic [XLEN-1:0]  opA, opB;
  logic [XLEN-1:0]  divisor, quo, rem;
  logic             negQ, negR;
  logic             rspValidQ;
  logic [XLEN-1:0]  rspDataQ;
  logic [TAG_W-1:0] rspTagQ;

  logic              aSigned, bSigned;
  logic [2*XLEN-1:0] aExt, bExt, prod;
  logic [XLEN-1:0]   mulResult;
  logic [XLEN:0]     partial, diff;
  logic [XLEN-1:0]   qFix, rFix;
  logic              aNeg, bNeg;

  // Full-width product of the latched operands, extended per funct3
  always_comb begin
    aSigned   = (funct3Q[1:0] == 2'b01) || (funct3Q[1:0] == 2'b10);
    bSigned   = (funct3Q[1:0] == 2'b01);
    aExt      = aSigned ? {{XLEN{opA[XLEN-1]}}, opA} : {{XLEN{1'b0}}, opA};
    bExt      = bSigned ? {{XLEN{opB[XLEN-1]}}, opB} : {{XLEN{1'b0}}, opB};
    prod      = aExt * bExt;
    mulResult = (funct3Q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Restoring divide step, operand signs and final sign correction
  always_comb begin
    partial = {rem, quo[XLEN-1]};
    diff    = partial - {1'b0, divisor};
    aNeg    = !funct3Q[0] && opA[XLEN-1];
    bNeg    = !funct3Q[0] && opB[XLEN-1];
    qFix    = negQ ? ('0 - quo) : quo;
    rFix    = negR ? ('0 - rem) : rem;
  end

  // Control FSM and datapath registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      funct3Q   <= '0;
      tagQ      <= '0;
      opA       <= '0;
      opB       <= '0;
      divisor   <= '0;
      quo       <= '0;
      rem       <= '0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      rspValidQ <= 1'b0;
      rspDataQ  <= '0;
      rspTagQ   <= '0;
    end else if (bus.Flush) begin
      state     <= IDLE;
      rspValidQ <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ReqValid) begin
            funct3Q <= bus.ReqFunct3;
            tagQ    <= bus.ReqTag;
            opA     <= bus.ReqRs1;
            opB     <= bus.ReqRs2;
            cnt     <= '0;
            // Special-case divides preload the final quotient/remainder with
            // signs cleared and reuse DIV_FIX as their single result cycle.
            if (!bus.ReqFunct3[2]) begin
              state <= MUL;
            end else if (bus.ReqRs2 == '0) begin
              quo   <= '1;
              rem   <= bus.ReqRs1;
              negQ  <= 1'b0;
              negR  <= 1'b0;
              state <= DIV_FIX;
            end else if (!bus.ReqFunct3[0] && bus.ReqRs1 == MOST_NEG && bus.ReqRs2 == '1) begin
              quo   <= bus.ReqRs1;
              rem   <= '0;
              negQ  <= 1'b0;
              negR  <= 1'b0;
              state <= DIV_FIX;
            end else begin
              state <= DIV_PREP;
            end
          end
        end
        MUL: begin
          if (cnt == CNT_W'(MUL_LAT - 1)) begin
            rspDataQ  <= mulResult;
            rspTagQ   <= tagQ;
            rspValidQ <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DIV_PREP: begin
          quo     <= aNeg ? ('0 - opA) : opA;
          divisor <= bNeg ? ('0 - opB) : opB;
          rem     <= '0;
          negQ    <= aNeg ^ bNeg;
          negR    <= aNeg;
          cnt     <= '0;
          state   <= DIV_ITER;
        end
        DIV_ITER: begin
          if (!diff[XLEN]) begin
            rem <= diff[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= partial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN - 1)) state <= DIV_FIX;
        end
        DIV_FIX: begin
          rspDataQ  <= funct3Q[1] ? rFix : qFix;
          rspTagQ   <= tagQ;
          rspValidQ <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (bus.RspReady) begin
            rspValidQ <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.RspValid = rspValidQ;
  assign bus.RspData  = rspDataQ;
  assign bus.RspTag   = rspTagQ;
  assign bus.Busy     = (state != IDLE);
  assign bus.ReqReady = (state == IDLE) && !Rst;

endmodule

// File: tb/tb_big_core_mul_div.sv
// Self-checking bench for big_core_mul_div (XLEN=32, MUL_LAT=2, TAG_W=5).
module tb_big_core_mul_div;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;
  localparam int TAG_W   = 5;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  big_core_mul_div_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  big_core_mul_div #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result of an M-extension op, from plain integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      la, lb, ua, ub, p;
    logic [63:0] pb;
    logic        ovf;
    sa  = a;
    sb  = b;
    la  = sa;
    lb  = sb;
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = la * lb; pb = p; return pb[31:0]; end
      3'd1: begin p = la * lb; pb = p; return pb[63:32]; end
      3'd2: begin p = la * ub; pb = p; return pb[63:32]; end
      3'd3: begin p = ua * ub; pb = p; return pb[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int modelLat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
  endfunction

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  bit   headSeen = 0;

  // Compare process: every cycle, outputs against the scoreboard
  always @(negedge Clk) begin
    if (Rst) begin
      check("rst_rspvalid", {63'b0, bus.RspValid}, 64'd0);
      check("rst_busy", {63'b0, bus.Busy}, 64'd0);
      check("rst_rspdata", {32'b0, bus.RspData}, 64'd0);
      check("rst_rsptag", {59'b0, bus.RspTag}, 64'd0);
      q.delete();
      headSeen = 0;
    end else begin
      check("reqready", {63'b0, bus.ReqReady}, {63'b0, q.size() == 0});
      check("busy", {63'b0, bus.Busy}, {63'b0, q.size() != 0});
      if (q.size() == 0) begin
        if (bus.RspValid) check("spurious_rspvalid", 64'd1, 64'd0);
      end else if (bus.RspValid) begin
        check("rsp_data", {32'b0, bus.RspData}, {32'b0, q[0].data});
        check("rsp_tag", {59'b0, bus.RspTag}, {59'b0, q[0].tag});
        if (!headSeen) begin
          check("rsp_latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
          headSeen = 1;
        end
        if (bus.RspReady) begin
          void'(q.pop_front());
          headSeen = 0;
        end
      end else if (headSeen) begin
        check("rspvalid_dropped", 64'd0, 64'd1);
        headSeen = 0;
        void'(q.pop_front());
      end else if (cyc - q[0].acc == q[0].lat) begin
        check("rsp_late", 64'd0, 64'd1);
      end
      if (bus.Flush) begin
        q.delete();
        headSeen = 0;
      end else if (bus.ReqValid && bus.ReqReady) begin
        q.push_back('{data: model(bus.ReqFunct3, bus.ReqRs1, bus.ReqRs2),
                      tag: bus.ReqTag, acc: cyc + 1,
                      lat: modelLat(bus.ReqFunct3, bus.ReqRs1, bus.ReqRs2)});
      end
    end
  end

  // Present one request for one cycle; inputs are scrambled after accept
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    @(posedge Clk); #1;
    bus.ReqValid  = 1'b1;
    bus.ReqFunct3 = f3;
    bus.ReqRs1    = a;
    bus.ReqRs2    = b;
    bus.ReqTag    = tag;
    @(posedge Clk); #1;
    bus.ReqValid  = 1'b0;
    bus.ReqFunct3 = 3'($urandom);
    bus.ReqRs1    = $urandom;
    bus.ReqRs2    = $urandom;
    bus.ReqTag    = 5'($urandom);
  endtask

  // Wait (bounded) for the response, check it, stall `hold` cycles, accept
  task automatic getRsp(input string name, input logic [31:0] expD, input logic [4:0] expT, input int hold);
    int n;
    n = 0;
    @(negedge Clk);
    while (!bus.RspValid && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (!bus.RspValid) begin
      check({name, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    check({name, "_data"}, {32'b0, bus.RspData}, {32'b0, expD});
    check({name, "_tag"}, {59'b0, bus.RspTag}, {59'b0, expT});
    repeat (hold) @(negedge Clk);
    if (hold > 0) begin
      check({name, "_held_data"}, {32'b0, bus.RspData}, {32'b0, expD});
      check({name, "_held_tag"}, {59'b0, bus.RspTag}, {59'b0, expT});
      check({name, "_held_reqready"}, {63'b0, bus.ReqReady}, 64'd0);
      check({name, "_held_busy"}, {63'b0, bus.Busy}, 64'd1);
    end
    @(posedge Clk); #1;
    bus.RspReady = 1'b1;
    @(posedge Clk); #1;
    bus.RspReady = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bus.ReqValid  = 1'b0;
    bus.ReqFunct3 = '0;
    bus.ReqRs1    = '0;
    bus.ReqRs2    = '0;
    bus.ReqTag    = '0;
    bus.Flush     = 1'b0;
    bus.RspReady  = 1'b0;

    // Pin the model against hand-computed values
    check("model_mul", {32'b0, model(3'd0, 32'd7, 32'hFFFF_FFFD)}, 64'hFFFF_FFEB);
    check("model_mulhsu", {32'b0, model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF)}, 64'hFFFF_FFFF);
    check("model_rem", {32'b0, model(3'd6, 32'hFFFF_FFF9, 32'd2)}, 64'hFFFF_FFFF);
    check("model_div_ovf", {32'b0, model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF)}, 64'h8000_0000);

    repeat (3) @(posedge Clk);
    #1;
    check("rst_reqready_low", {63'b0, bus.ReqReady}, 64'd0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("reqready_after_rst", {63'b0, bus.ReqReady}, 64'd1);

    vecs.push_back('{"mul",       3'd0, 32'd7,          32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFEB});
    vecs.push_back('{"mulh",      3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000});
    vecs.push_back('{"mulhsu",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF});
    vecs.push_back('{"mulhu",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE});
    vecs.push_back('{"div",       3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD});
    vecs.push_back('{"rem",       3'd6, 32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFF});
    vecs.push_back('{"divu",      3'd5, 32'd100,        32'd7,         5'd6,  32'd14});
    vecs.push_back('{"remu",      3'd7, 32'd100,        32'd7,         5'd7,  32'd2});
    vecs.push_back('{"divu_zero", 3'd5, 32'd5,          32'd0,         5'd8,  32'hFFFF_FFFF});
    vecs.push_back('{"remu_zero", 3'd7, 32'd5,          32'd0,         5'd10, 32'd5});
    vecs.push_back('{"div_zero",  3'd4, 32'hFFFF_FFF0,  32'd0,         5'd11, 32'hFFFF_FFFF});
    vecs.push_back('{"div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000});
    vecs.push_back('{"rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'd0});
    vecs.push_back('{"div_neg",   3'd4, 32'd100,        32'hFFFF_FFF9, 5'd14, 32'hFFFF_FFF2});

    foreach (vecs[i]) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].tag);
      getRsp(vecs[i].name, vecs[i].exp, vecs[i].tag, 0);
    end

    // Backpressure, then a new MUL straight after release
    issue(3'd0, 32'd12345, 32'd678, 5'd17);
    getRsp("bp_mul", 32'd8369910, 5'd17, 3);
    @(negedge Clk);
    check("bp_reqready_after", {63'b0, bus.ReqReady}, 64'd1);
    issue(3'd0, 32'hFFFF_FFFF, 32'd3, 5'd18);
    getRsp("bp_next", 32'hFFFF_FFFD, 5'd18, 0);

    // Flush 10 cycles into a divide, with a concurrent request
    issue(3'd4, 32'd1000, 32'd3, 5'd19);
    repeat (9) @(posedge Clk);
    #1;
    bus.Flush    = 1'b1;
    bus.ReqValid = 1'b1;
    @(posedge Clk); #1;
    bus.Flush    = 1'b0;
    bus.ReqValid = 1'b0;
    @(negedge Clk);
    check("flush_reqready", {63'b0, bus.ReqReady}, 64'd1);
    repeat (40) @(negedge Clk);
    check("flush_no_rsp", {63'b0, bus.RspValid}, 64'd0);

    // Flush while idle blocks a same-cycle request
    @(posedge Clk); #1;
    bus.Flush     = 1'b1;
    bus.ReqValid  = 1'b1;
    bus.ReqFunct3 = 3'd5;
    bus.ReqRs1    = 32'd9;
    bus.ReqRs2    = 32'd3;
    @(posedge Clk); #1;
    bus.Flush    = 1'b0;
    bus.ReqValid = 1'b0;
    @(negedge Clk);
    check("flush_idle_not_accepted", {63'b0, bus.Busy}, 64'd0);

    issue(3'd5, 32'd9, 32'd3, 5'd20);
    getRsp("divu_after_flush", 32'd3, 5'd20, 0);

    // Reset in the middle of a multiply
    issue(3'd0, 32'd6, 32'd7, 5'd21);
    #1;
    Rst = 1'b1;
    #1;
    check("midrst_rspvalid", {63'b0, bus.RspValid}, 64'd0);
    check("midrst_busy", {63'b0, bus.Busy}, 64'd0);
    check("midrst_rspdata", {32'b0, bus.RspData}, 64'd0);
    check("midrst_rsptag", {59'b0, bus.RspTag}, 64'd0);
    check("midrst_reqready", {63'b0, bus.ReqReady}, 64'd0);
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    repeat (5) @(negedge Clk);
    check("midrst_no_rsp", {63'b0, bus.RspValid}, 64'd0);
    issue(3'd7, 32'hFFFF_FFFF, 32'd10, 5'd22);
    getRsp("remu_after_rst", 32'd5, 5'd22, 0);

    repeat (3) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
